// File: rtl/instr_fetch_mem.sv
// Instruction memory with an autonomous PC sequencer that presents opcodes and decoded fields over valid/ready.
// Define INSTR_FETCH_MEM_HALT_EN to let a HALT_OP opcode end a run early.
module instr_fetch_mem #(
  parameter int         DEPTH   = 16,
  parameter int         AW      = 4,
  parameter int         DATA_W  = 27,
  parameter logic [4:0] HALT_OP = 5'b11111
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [AW-1:0]     start_addr,
  input  logic [AW-1:0]     end_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data,
  output logic [AW-1:0]     data_addr,
  output logic [4:0]        data_instr,
  output logic [6:0]        data_dest,
  output logic [6:0]        data_src1,
  output logic [6:0]        data_src2,
  output logic [7:0]        data_scalar,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, VALID, DONE} state_t;

  state_t            state;
  logic [AW-1:0]     pc;
  logic [AW-1:0]     end_pc;
  logic [AW-1:0]     pc_next;
  logic [DATA_W-1:0] rd_word;
  logic              last_word;
  logic [DATA_W-1:0] mem [DEPTH];

  // Zero-extend before comparing so the check stays meaningful when DEPTH == 2^AW.
  function automatic logic in_range(input logic [AW-1:0] a);
    logic [31:0] ext;
    ext = 32'(a);
    return ext < 32'(DEPTH);
  endfunction

  assign rd_word = mem[pc[IW-1:0]];
  assign pc_next = (pc == AW'(DEPTH - 1)) ? '0 : pc + AW'(1);
  assign busy    = (state != IDLE);

`ifdef INSTR_FETCH_MEM_HALT_EN
  assign last_word = (pc == end_pc) || (data_instr == HALT_OP);
`else
  logic unused_halt;
  assign unused_halt = ^HALT_OP;
  assign last_word   = (pc == end_pc);
`endif

  // Program store is never reset; the NBA write gives read-first behaviour against the FETCH read.
  always_ff @(posedge clk) begin
    if (wr_en && in_range(wr_addr)) begin
      mem[wr_addr[IW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      end_pc      <= '0;
      out_valid   <= 1'b0;
      data        <= '0;
      data_addr   <= '0;
      data_instr  <= '0;
      data_dest   <= '0;
      data_src1   <= '0;
      data_src2   <= '0;
      data_scalar <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (wr_en && !in_range(wr_addr)) begin
        err <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            if (!in_range(start_addr) || !in_range(end_addr)) begin
              err <= 1'b1;
            end else begin
              pc     <= start_addr;
              end_pc <= end_addr;
              state  <= FETCH;
            end
          end
        end
        FETCH: begin
          data        <= rd_word;
          data_addr   <= pc;
          data_instr  <= rd_word[DATA_W-1 -: 5];
          data_dest   <= rd_word[DATA_W-6 -: 7];
          data_src1   <= rd_word[DATA_W-13 -: 7];
          data_src2   <= rd_word[7:1];
          data_scalar <= rd_word[7:0];
          out_valid   <= 1'b1;
          state       <= VALID;
        end
        VALID: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last_word) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              pc    <= pc_next;
              state <= FETCH;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Scoreboard bench for instr_fetch_mem, built with AW=5 so out-of-range addresses can be driven.
// Define INSTR_FETCH_MEM_HALT_EN for both bench and RTL to exercise the halt opcode.
module tb_instr_fetch_mem;

  localparam int         DEPTH   = 16;
  localparam int         AW      = 5;
  localparam int         DATA_W  = 27;
  localparam logic [4:0] HALT_OP = 5'b11111;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              start;
  logic [AW-1:0]     start_addr;
  logic [AW-1:0]     end_addr;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] data;
  logic [AW-1:0]     data_addr;
  logic [4:0]        data_instr;
  logic [6:0]        data_dest;
  logic [6:0]        data_src1;
  logic [6:0]        data_src2;
  logic [7:0]        data_scalar;
  logic              busy;
  logic              done;
  logic              err;

  always #5 clk = ~clk;

  instr_fetch_mem #(
    .DEPTH(DEPTH), .AW(AW), .DATA_W(DATA_W), .HALT_OP(HALT_OP)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .start_addr(start_addr), .end_addr(end_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .data(data), .data_addr(data_addr),
    .data_instr(data_instr), .data_dest(data_dest), .data_src1(data_src1),
    .data_src2(data_src2), .data_scalar(data_scalar),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct packed {
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] word;
  } exp_t;

  int                vectors = 0;
  int                miscompares = 0;
  logic [DATA_W-1:0] shadow [DEPTH];
  exp_t              sb [$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Fields are sliced independently from the expected word.
  task automatic checkWord(input exp_t e);
    checkOutput("data", 32'(data), 32'(e.word));
    checkOutput("data_addr", 32'(data_addr), 32'(e.addr));
    checkOutput("data_instr", 32'(data_instr), 32'(e.word[26:22]));
    checkOutput("data_dest", 32'(data_dest), 32'(e.word[21:15]));
    checkOutput("data_src1", 32'(data_src1), 32'(e.word[14:8]));
    checkOutput("data_src2", 32'(data_src2), 32'(e.word[7:1]));
    checkOutput("data_scalar", 32'(data_scalar), 32'(e.word[7:0]));
  endtask

  task automatic writeWord(input int a, input logic [DATA_W-1:0] w);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = w;
    @(negedge clk);
    wr_en = 1'b0;
    if (a < DEPTH) shadow[a] = w;
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs one program pass from sa to ea; stall_word is held with out_ready low for stall_cycles.
  task automatic applyStimulus(input int sa, input int ea, input int stall_word,
                               input int stall_cycles, input bit timed);
    int   a;
    int   n;
    int   k;
    int   idx;
    int   stalled;
    bit   seen_done;
    exp_t e;
    sb.delete();
    a = sa;
    for (int g = 0; g < DEPTH; g++) begin
      e.addr = AW'(a);
      e.word = shadow[a];
      sb.push_back(e);
`ifdef INSTR_FETCH_MEM_HALT_EN
      if (e.word[26:22] == HALT_OP) break;
`endif
      if (a == ea) break;
      a = (a == DEPTH - 1) ? 0 : a + 1;
    end
    n = sb.size();
    start      = 1'b1;
    start_addr = AW'(sa);
    end_addr   = AW'(ea);
    out_ready  = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    k         = 0;
    idx       = 0;
    stalled   = 0;
    seen_done = 1'b0;
    for (int c = 0; c < 200 && !seen_done; c++) begin
      @(negedge clk);
      k++;
      if (done) begin
        seen_done = 1'b1;
        checkOutput("word_count", 32'(idx), 32'(n));
        if (timed) checkOutput("done_timing", 32'(k), 32'(2 * n));
      end else if (out_valid) begin
        if (sb.size() == 0) begin
          checkOutput("extra_word", 32'(idx), 32'(n - 1));
          out_ready = 1'b1;
        end else begin
          checkWord(sb[0]);
          if (idx == stall_word && stalled < stall_cycles) begin
            out_ready  = 1'b0;
            start      = 1'b1;
            start_addr = AW'(9);
            stalled++;
          end else begin
            out_ready = 1'b1;
            start     = 1'b0;
            if (timed) checkOutput("valid_timing", 32'(k), 32'(2 * idx + 1));
            void'(sb.pop_front());
            idx++;
          end
        end
      end else begin
        out_ready = 1'b1;
        start     = 1'b0;
      end
    end
    start = 1'b0;
    checkOutput("done_seen", 32'(seen_done), 32'(1));
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(done), 32'(0));
    checkOutput("busy_after_done", 32'(busy), 32'(0));
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int        found;
    exp_t      e;
    logic [DATA_W-1:0] old_word;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; start_addr = '0; end_addr = '0; out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    $display("[TB] reset state");
    checkOutput("rst_valid", 32'(out_valid), 32'(0));
    checkOutput("rst_data", 32'(data), 32'(0));
    checkOutput("rst_addr", 32'(data_addr), 32'(0));
    checkOutput("rst_instr", 32'(data_instr), 32'(0));
    checkOutput("rst_scalar", 32'(data_scalar), 32'(0));
    checkOutput("rst_done", 32'(done), 32'(0));
    checkOutput("rst_err", 32'(err), 32'(0));
    checkOutput("rst_busy", 32'(busy), 32'(0));

    writeWord(0, 27'h0000002);
    writeWord(1, 27'h1008004);
    writeWord(2, 27'h4004000);
    writeWord(3, 27'h2802A2A);
    writeWord(4, 27'h3428008);
    writeWord(14, 27'h6A1B2C3);
    writeWord(15, 27'h15A5A5A);

    $display("[TB] basic run 0..4");
    applyStimulus(0, 4, -1, 0, 1'b1);
    $display("[TB] backpressure on word 1");
    applyStimulus(0, 4, 1, 5, 1'b0);
    $display("[TB] wrap run 14..1");
    applyStimulus(14, 1, -1, 0, 1'b1);
    $display("[TB] single word run");
    applyStimulus(3, 3, -1, 0, 1'b1);

    $display("[TB] out-of-range write");
    writeWord(16, 27'h5555555);
    checkOutput("err_wr_oob", 32'(err), 32'(1));
    applyStimulus(0, 0, -1, 0, 1'b1);
    checkOutput("err_sticky", 32'(err), 32'(1));
    pulseReset();
    checkOutput("err_cleared", 32'(err), 32'(0));

    $display("[TB] out-of-range start");
    start = 1'b1; start_addr = AW'(0); end_addr = AW'(16);
    @(negedge clk);
    start = 1'b0;
    checkOutput("err_bad_end", 32'(err), 32'(1));
    checkOutput("busy_bad_end", 32'(busy), 32'(0));
    @(negedge clk);
    checkOutput("busy_bad_end2", 32'(busy), 32'(0));
    checkOutput("done_bad_end", 32'(done), 32'(0));
    checkOutput("valid_bad_end", 32'(out_valid), 32'(0));
    pulseReset();
    start = 1'b1; start_addr = AW'(20); end_addr = AW'(2);
    @(negedge clk);
    start = 1'b0;
    checkOutput("err_bad_start", 32'(err), 32'(1));
    checkOutput("busy_bad_start", 32'(busy), 32'(0));
    pulseReset();

    $display("[TB] reset mid-run");
    start = 1'b1; start_addr = AW'(0); end_addr = AW'(4); out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 40 && found == 0; c++) begin
      @(negedge clk);
      if (out_valid && data_addr == AW'(2)) found = 1;
    end
    checkOutput("reached_word2", 32'(data_addr), 32'(2));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midrst_valid", 32'(out_valid), 32'(0));
    checkOutput("midrst_busy", 32'(busy), 32'(0));
    checkOutput("midrst_done", 32'(done), 32'(0));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("midrst_no_done", 32'(done), 32'(0));
    end
    applyStimulus(0, 4, -1, 0, 1'b1);

    $display("[TB] read-first collision");
    old_word = shadow[3];
    start = 1'b1; start_addr = AW'(3); end_addr = AW'(3); out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b1; wr_addr = AW'(3); wr_data = 27'h0ABCDEF;
    @(negedge clk);
    wr_en = 1'b0;
    shadow[3] = 27'h0ABCDEF;
    checkOutput("rf_valid", 32'(out_valid), 32'(1));
    checkOutput("rf_old_word", 32'(data), 32'(old_word));
    @(negedge clk);
    checkOutput("rf_done", 32'(done), 32'(1));
    @(negedge clk);
    applyStimulus(3, 3, -1, 0, 1'b1);

    $display("[TB] halt opcode at address 2");
    writeWord(2, 27'h7C00000);
    applyStimulus(0, 4, -1, 0, 1'b1);
    writeWord(2, 27'h4004000);
    e.addr = AW'(2);
    e.word = shadow[2];
    applyStimulus(2, 2, -1, 0, 1'b1);
    checkOutput("instr_addr2", 32'(e.word[26:22]), 32'(5'b10000));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
